tile_loader: RTL and testbench
==============================

TILE_LOADER -- requirements
Module: tile_loader

Interface
REQ-001 SHALL have parameter IMG_W, default 400, image width/height in pixels.
REQ-002 SHALL have parameter TILE, default 10, tile edge in pixels.
REQ-003 SHALL have parameter ROM_LAT, default 2, clock edges from the edge registering rom_addr to the edge sampling rom_data.
REQ-004 SHALL have port clk  in  1  single clock (25 MHz domain); one clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  request a tile load, sampled only in IDLE.
REQ-007 SHALL have port tile_x  in  6  tile column index, 0..IMG_W/TILE-1.
REQ-008 SHALL have port tile_y  in  6  tile row index, 0..IMG_W/TILE-1.
REQ-009 SHALL have port rom_addr  out  18  registered ROM port-A address.
REQ-010 SHALL have port rom_data  in  8  ROM port-A pixel.
REQ-011 SHALL have port tile  out  TILE x TILE x 16 signed  loaded matrix, [row][col], fed to the NPU input_matrix.
REQ-012 SHALL have port busy  out  1  high from the start-accept edge until done.
REQ-013 SHALL have port done  out  1  one-cycle pulse: tile complete or rejected.
REQ-014 SHALL have port err  out  1  one-cycle pulse with done when coordinates are out of range.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN, FINISH; IDLE->ISSUE on start with valid coordinates; ISSUE->DRAIN after issuing index TILE*TILE-1; DRAIN->FINISH on the last capture; FINISH->IDLE unconditionally.
REQ-016 SHALL, on accepting start (edge 0), latch tile_x/tile_y, raise busy and register rom_addr for pixel (0,0).
REQ-017 SHALL issue one address per clock in row-major order: index k registered at edge k, k=0..99.
REQ-018 SHALL compute address (tile_y*TILE+r)*IMG_W + tile_x*TILE + c incrementally: +1 per column and row base +IMG_W on column wrap; no per-cycle multiplier. Maximum 159999 fits in 18 bits.
REQ-019 SHALL capture rom_data for index k at edge k+ROM_LAT into tile[r][c] as {8'h00, rom_data}, using a ROM_LAT-deep delayed copy of (r,c) and a valid bit.
REQ-020 SHALL write the last element at edge 99+ROM_LAT and assert done (registered) for the following single cycle, with busy dropping at that same edge; with ROM_LAT=2 start-to-done is 101 edges.
REQ-021 SHALL update tile entries progressively while busy; entries not yet rewritten hold prior values; after done all 100 entries belong to the new tile.
REQ-022 SHALL ignore start while busy or while done is high.
REQ-023 SHALL, if tile_x or tile_y exceeds IMG_W/TILE-1 when start is sampled, issue no reads, leave tile unchanged, and pulse done and err together on the next cycle.
REQ-024 SHALL hold rom_addr at its last value when not in ISSUE.
REQ-025 SHALL accept a new start on the cycle after done (back-to-back tiles).

Reset
REQ-026 SHALL, on rst high at any clock edge, including mid-load, go to IDLE and clear busy, done, err, rom_addr, all counters, delay-line valid bits and every tile entry to 0.
REQ-027 SHALL give rst priority over start in the same cycle.

Structure
REQ-028 SHALL place IMG_W, TILE, TILES_PER_SIDE (40), PIX_W (8), MAT_W (16) and the state enum in shared package npu_pkg, which the top-level FSM and NPU also use.
REQ-029 SHALL factor the row/column counters and incremental address into one sub-module, tile_addr_gen.

Verification
REQ-030 SHALL verify tile_x=0, tile_y=0 with ROM modelled as mem[a]=a[7:0]: rom_addr 0..9, 400..409, ..., 3600..3609; tile[r][c]=(400r+c)&255; done at edge 101.
REQ-031 SHALL verify tile_x=39, tile_y=39: first address 156390, last 159999, err=0.
REQ-032 SHALL verify tile_x=40: done=err=1 one cycle after start, rom_addr unchanged, tile unchanged.
REQ-033 SHALL verify rst asserted at edge 50 of a load: next cycle busy=0, every tile entry 0, and a fresh start loads correctly.
REQ-034 SHALL verify start held high for the whole load and two tiles loaded back-to-back (1,0) then (2,0): second load starts the cycle after the first done; its first address is 20.
REQ-035 SHALL verify pixel 0xFF is captured as 16'h00FF (positive, zero-extended).

Source files
------------

// File: rtl/npu_pkg.sv
// npu_pkg: constants and state type shared by the tile loader, top-level FSM and NPU
package npu_pkg;
    localparam int IMG_W          = 400;
    localparam int TILE           = 10;
    localparam int TILES_PER_SIDE = IMG_W / TILE;
    localparam int PIX_W          = 8;
    localparam int MAT_W          = 16;
    localparam int ADDR_W         = 18;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
endpackage

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: row/column counters and incremental row-major ROM address for one tile
module tile_addr_gen #(
    parameter int IMG_W = npu_pkg::IMG_W,
    parameter int TILE  = npu_pkg::TILE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic                        step,
    input  logic [5:0]                  tx,
    input  logic [5:0]                  ty,
    output logic [npu_pkg::ADDR_W-1:0]  addr,
    output logic [$clog2(TILE)-1:0]     nr,
    output logic [$clog2(TILE)-1:0]     nc
);
    import npu_pkg::*;
    localparam int CW = $clog2(TILE);
    logic [CW-1:0] r, c;
    logic [ADDR_W-1:0] row_base, next_base, next_addr;
    logic wrap;
    // next index/address; the only multiply happens once, when a tile is loaded
    always_comb begin
        wrap      = c == CW'(TILE - 1);
        next_base = load ? ADDR_W'(ty) * ADDR_W'(TILE * IMG_W) + ADDR_W'(tx) * ADDR_W'(TILE)
                  : wrap ? row_base + ADDR_W'(IMG_W) : row_base;
        next_addr = (load || wrap) ? next_base : addr + 1'b1;
        nr        = load ? '0 : wrap ? r + 1'b1 : r;
        nc        = (load || wrap) ? '0 : c + 1'b1;
    end
    // counters and address advance only on load or step, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r        <= '0;
            c        <= '0;
            row_base <= '0;
            addr     <= '0;
        end else if (load || step) begin
            r        <= nr;
            c        <= nc;
            row_base <= next_base;
            addr     <= next_addr;
        end
    end
endmodule

// File: rtl/tile_loader.sv
// tile_loader: streams one TILE x TILE pixel tile from ROM into a signed matrix for the NPU
module tile_loader #(
    parameter int IMG_W   = npu_pkg::IMG_W,
    parameter int TILE    = npu_pkg::TILE,
    parameter int ROM_LAT = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [5:0]                        tile_x,
    input  logic [5:0]                        tile_y,
    output logic [npu_pkg::ADDR_W-1:0]        rom_addr,
    input  logic [npu_pkg::PIX_W-1:0]         rom_data,
    output logic signed [npu_pkg::MAT_W-1:0]  tile [TILE][TILE],
    output logic                              busy,
    output logic                              done,
    output logic                              err
);
    import npu_pkg::*;
    localparam int TPS = IMG_W / TILE;
    localparam int CW  = $clog2(TILE);
    state_t state;
    logic ok, accept, issuing;
    logic [CW-1:0] nr, nc;
    logic vld [ROM_LAT];
    logic [CW-1:0] rp [ROM_LAT];
    logic [CW-1:0] cp [ROM_LAT];
    // start is only looked at in IDLE; done is high only in FINISH, so it is ignored then too
    always_comb begin
        ok      = tile_x <= 6'(TPS - 1) && tile_y <= 6'(TPS - 1);
        accept  = state == IDLE && start;
        issuing = (accept && ok) || state == ISSUE;
    end
    tile_addr_gen #(.IMG_W(IMG_W), .TILE(TILE)) u_gen (
        .clk  (clk),
        .rst  (rst),
        .load (accept && ok),
        .step (state == ISSUE),
        .tx   (tile_x),
        .ty   (tile_y),
        .addr (rom_addr),
        .nr   (nr),
        .nc   (nc)
    );
    // control FSM; bad coordinates skip straight to FINISH with done and err
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state <= ok ? ISSUE : FINISH;
                    busy  <= ok;
                    done  <= !ok;
                    err   <= !ok;
                end
                ISSUE: if (nr == CW'(TILE - 1) && nc == CW'(TILE - 1)) state <= DRAIN;
                DRAIN: if (vld[ROM_LAT-1] && rp[ROM_LAT-1] == CW'(TILE - 1) && cp[ROM_LAT-1] == CW'(TILE - 1)) begin
                    state <= FINISH;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // (row, col, valid) of each issued index, delayed to line up with rom_data
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                vld[i] <= 1'b0;
                rp[i]  <= '0;
                cp[i]  <= '0;
            end
        end else begin
            vld[0] <= issuing;
            rp[0]  <= nr;
            cp[0]  <= nc;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld[i] <= vld[i-1];
                rp[i]  <= rp[i-1];
                cp[i]  <= cp[i-1];
            end
        end
    end
    // capture pixels zero-extended so they stay positive in the signed matrix
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < TILE; r++)
                for (int c = 0; c < TILE; c++)
                    tile[r][c] <= '0;
        end else if (vld[ROM_LAT-1]) begin
            tile[rp[ROM_LAT-1]][cp[ROM_LAT-1]] <= MAT_W'(rom_data);
        end
    end
endmodule

// File: tb/tb_tile_loader.sv
// tb_tile_loader: directed self-checking bench for tile_loader with a 2-cycle ROM holding mem[a]=a[7:0]
module tb_tile_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [5:0] tile_x = '0;
    logic [5:0] tile_y = '0;
    logic [17:0] rom_addr;
    logic [7:0] rom_data = '0;
    logic signed [15:0] tile [10][10];
    logic busy, done, err;
    int checks = 0;
    int failures = 0;

    tile_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tile_x   (tile_x),
        .tile_y   (tile_y),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .tile     (tile),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // one register stage here plus the DUT's registered address gives two edges of latency
    always @(posedge clk) rom_data <= rom_addr[7:0];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // full load: start sampled at edge 0, addresses checked each edge, done at edge 101, pulse gone at 102
    task automatic run_load(input int x, input int y, input bit hold);
        int base;
        base = y * 4000 + x * 10;
        tile_x = 6'(x);
        tile_y = 6'(y);
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        check("busy_on", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 100; k++) begin
            if (k > 0) tick();
            check("rom_addr", {14'd0, rom_addr}, 32'(base + 400 * (k / 10) + k % 10));
        end
        tick();
        check("done_early", {31'd0, done}, 32'd0);
        tick();
        check("done", {31'd0, done}, 32'd1);
        check("busy_off", {31'd0, busy}, 32'd0);
        check("err_clear", {31'd0, err}, 32'd0);
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                check("tile_px", 32'(tile[r][c]), 32'((base + 400 * r + c) & 255));
        tick();
        check("done_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        // reset wins over a simultaneous start
        start = 1'b1;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_addr", {14'd0, rom_addr}, 32'd0);
        check("rst_tile00", 32'(tile[0][0]), 32'd0);
        check("rst_tile99", 32'(tile[9][9]), 32'd0);
        start = 1'b0;
        rst = 1'b0;
        tick();

        // corner tile (0,0)
        run_load(0, 0, 1'b0);

        // far corner (39,39): 156390..159999, last pixel 0xFF must stay positive
        run_load(39, 39, 1'b0);
        check("ff_zero_ext", 32'(tile[9][9]), 32'h0000_00FF);

        // out-of-range column: immediate done+err, no reads, tile untouched
        tile_x = 6'd40;
        tile_y = 6'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("bad_done", {31'd0, done}, 32'd1);
        check("bad_err", {31'd0, err}, 32'd1);
        check("bad_busy", {31'd0, busy}, 32'd0);
        check("bad_addr", {14'd0, rom_addr}, 32'd159999);
        tick();
        check("bad_done_pulse", {31'd0, done}, 32'd0);
        check("bad_err_pulse", {31'd0, err}, 32'd0);
        check("bad_addr_hold", {14'd0, rom_addr}, 32'd159999);
        check("bad_tile00", 32'(tile[0][0]), 32'd230);
        check("bad_tile99", 32'(tile[9][9]), 32'd255);

        // reset at edge 50 of a load clears everything, then a fresh load works
        tile_x = 6'd0;
        tile_y = 6'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (49) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_addr", {14'd0, rom_addr}, 32'd0);
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                check("mid_rst_tile", 32'(tile[r][c]), 32'd0);
        tick();
        run_load(0, 0, 1'b0);

        // start held high: (1,0) then (2,0) back to back
        run_load(1, 0, 1'b1);
        check("b2b_gap_busy", {31'd0, busy}, 32'd0);
        check("b2b_gap_addr", {14'd0, rom_addr}, 32'd3619);
        run_load(2, 0, 1'b1);
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
